// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side byte packer: byte width,
// packer state encoding and a lane-mask helper.
package fifo_rd_packer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } pk_state_e;

  // Byte lane `lane` carries data when fewer than `cnt` lanes precede it.
  function automatic logic lane_on(input int cnt, input int lane);
    return (lane < cnt);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read-side and packed-word output handshake bundle; the packer is the
// master, the FIFO plus downstream consumer form the slave side.
interface fifo_rd_packer_if #(
  parameter int BYTES = 4
);
  import fifo_rd_packer_pkg::*;

  logic                      fifo_empty;
  logic [BYTE_W-1:0]         fifo_data;
  logic                      fifo_rd_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [BYTE_W*BYTES-1:0]   out_data;
  logic [BYTES-1:0]          out_keep;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_keep
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/fifo_rd_packer.sv
// Packs bytes read from an async FIFO into little-endian BYTES-wide words,
// with a flush path that emits a partially filled word.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int CW    = 16
) (
  input  logic             rclk,
  input  logic             rst,
  fifo_rd_packer_if.master bus,
  input  logic             flush,
  output logic             flush_done,
  output logic [CW-1:0]    word_cnt
);

  localparam int LW    = $clog2(BYTES);
  localparam int CNT_W = LW + 1;
  localparam int DW    = BYTE_W * BYTES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES);

  pk_state_e          state_r;
  logic [DW-1:0]      acc_r;
  logic [CNT_W-1:0]   acc_cnt_r;
  logic               pend_r;
  logic               out_valid_r;
  logic [DW-1:0]      out_data_r;
  logic [BYTES-1:0]   out_keep_r;
  logic               flush_done_r;
  logic [CW-1:0]      word_cnt_r;

  logic               xfer_s;
  logic               out_free_s;
  logic [CNT_W-1:0]   fill_cnt_s;
  logic [LW-1:0]      lane_s;
  logic               rd_en_s;
  logic [DW-1:0]      acc_nxt_s;
  logic [BYTES-1:0]   part_keep_s;
  logic               full_mv_s;
  logic               emit_mv_s;
  logic               load_s;
  logic [BYTES-1:0]   load_keep_s;

  // fill_cnt_s counts the byte still in flight, so a word completes on the
  // same edge its last byte arrives.
  assign xfer_s      = out_valid_r & bus.out_ready;
  assign out_free_s  = ~out_valid_r | bus.out_ready;
  assign fill_cnt_s  = acc_cnt_r + CNT_W'(pend_r);
  assign lane_s      = acc_cnt_r[LW-1:0];
  assign rd_en_s     = rst & (state_r == FILL) & ~bus.fifo_empty &
                       ((fill_cnt_s < FULL_CNT) | out_free_s);
  assign full_mv_s   = (fill_cnt_s == FULL_CNT) & out_free_s;
  assign emit_mv_s   = (state_r == EMIT) & out_free_s;
  assign load_s      = full_mv_s | emit_mv_s;
  assign load_keep_s = full_mv_s ? {BYTES{1'b1}} : part_keep_s;

  // Accumulator contents including the byte arriving this cycle.
  always_comb begin
    acc_nxt_s = acc_r;
    if (pend_r) begin
      acc_nxt_s[lane_s*BYTE_W +: BYTE_W] = bus.fifo_data;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Keep mask for a partial word: the low acc_cnt lanes.
  always_comb begin
    part_keep_s = {BYTES{1'b0}};
    for (int i = 0; i < BYTES; i++) begin
      part_keep_s[i] = lane_on(32'(acc_cnt_r), i);
    end
  end

  // Accumulator, one-entry output register and transfer counter.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      pend_r      <= 1'b0;
      acc_r       <= DW'(0);
      acc_cnt_r   <= CNT_W'(0);
      out_valid_r <= 1'b0;
      out_data_r  <= DW'(0);
      out_keep_r  <= BYTES'(0);
      word_cnt_r  <= CW'(0);
    end else begin
      pend_r <= rd_en_s;
      if (load_s) begin
        acc_r       <= DW'(0);
        acc_cnt_r   <= CNT_W'(0);
        out_valid_r <= 1'b1;
        out_data_r  <= acc_nxt_s;
        out_keep_r  <= load_keep_s;
      end else begin
        acc_r     <= acc_nxt_s;
        acc_cnt_r <= fill_cnt_s;
        if (xfer_s) begin
          out_valid_r <= 1'b0;
        end
      end
      if (xfer_s) begin
        word_cnt_r <= word_cnt_r + CW'(1);
      end
    end
  end

  // Flush sequencing: stop reading, let the in-flight byte land, then push
  // out whatever partial word remains.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_r      <= FILL;
      flush_done_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          flush_done_r <= 1'b0;
          state_r      <= flush ? DRAIN : FILL;
        end
        DRAIN: begin
          if (pend_r || (acc_cnt_r == FULL_CNT)) begin
            flush_done_r <= 1'b0;
            state_r      <= DRAIN;
          end else if (acc_cnt_r == CNT_W'(0)) begin
            flush_done_r <= 1'b1;
            state_r      <= FILL;
          end else begin
            flush_done_r <= 1'b0;
            state_r      <= EMIT;
          end
        end
        EMIT: begin
          flush_done_r <= out_free_s;
          state_r      <= out_free_s ? FILL : EMIT;
        end
        default: begin
          flush_done_r <= 1'b0;
          state_r      <= FILL;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_keep   = out_keep_r;
  assign flush_done     = flush_done_r;
  assign word_cnt       = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: emulated FIFO source, queue-based word model and a
// per-cycle compare process, plus directed literal expectations.
module tb_fifo_rd_packer;

  localparam int BYTES = 4;
  localparam int CW    = 16;
  localparam int DW    = 8 * BYTES;

  typedef struct packed {
    logic [DW-1:0]    d;
    logic [BYTES-1:0] k;
  } word_t;

  logic          rclk = 1'b0;
  logic          rst;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] word_cnt;

  fifo_rd_packer_if #(.BYTES(BYTES)) bus ();

  fifo_rd_packer #(.BYTES(BYTES), .CW(CW)) dut (
    .rclk       (rclk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .word_cnt   (word_cnt)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_full_cyc = 0;
  int valid_rise_cyc = 0;
  int flush_out = 0;
  int fd_pulses = 0;
  int bytes_acc = 0;
  int model_wc = 0;
  int empty_rate = 0;
  int ready_rate = 100;
  bit acc_pending = 1'b0;
  bit force_ne = 1'b0;
  bit flush_req = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_fd = 1'b0;
  logic [DW-1:0]    prev_data = '0;
  logic [BYTES-1:0] prev_keep = '0;

  logic [7:0] src_q[$];
  logic [7:0] grp[$];
  word_t      exp_q[$];
  word_t      seen_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_group();
    word_t w;
    w = '0;
    foreach (grp[i]) begin
      w.d[8*i +: 8] = grp[i];
      w.k[i]        = 1'b1;
    end
    exp_q.push_back(w);
    grp.delete();
  endtask

  // Compare process: model bookkeeping and output checks on every falling edge.
  always @(negedge rclk) begin
    cyc++;
    if (!rst) begin
      acc_pending = 1'b0;
      grp.delete();
      exp_q.delete();
      model_wc   = 0;
      flush_out  = 0;
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
      prev_fd    = 1'b0;
      chk("rst_out_valid",  64'(bus.out_valid),  64'(0));
      chk("rst_out_data",   64'(bus.out_data),   64'(0));
      chk("rst_out_keep",   64'(bus.out_keep),   64'(0));
      chk("rst_flush_done", 64'(flush_done),     64'(0));
      chk("rst_word_cnt",   64'(word_cnt),       64'(0));
      chk("rst_rd_en",      64'(bus.fifo_rd_en), 64'(0));
    end else begin
      chk("rd_en_while_empty", 64'(bus.fifo_rd_en & bus.fifo_empty), 64'(0));
      acc_pending = bus.fifo_rd_en && !bus.fifo_empty;
      if (acc_pending) begin
        grp.push_back(src_q[0]);
        bytes_acc++;
        if (grp.size() == BYTES) begin
          push_group();
          last_full_cyc = cyc;
        end
      end
      if (flush_done) begin
        fd_pulses++;
        chk("flush_done_owed",  64'(flush_out > 0), 64'(1));
        chk("flush_done_pulse", 64'(prev_fd),       64'(0));
        if (flush_out > 0) flush_out--;
      end
      if (flush) begin
        if (grp.size() != 0) push_group();
        flush_out++;
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data",  64'(bus.out_data),  64'(prev_data));
        chk("hold_keep",  64'(bus.out_keep),  64'(prev_keep));
      end
      if (bus.out_valid && !prev_valid) valid_rise_cyc = cyc;
      chk("word_cnt", 64'(word_cnt), 64'(CW'(model_wc)));
      if (bus.out_valid && bus.out_ready) begin
        word_t w;
        w.d = bus.out_data;
        w.k = bus.out_keep;
        seen_q.push_back(w);
        model_wc++;
        chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          word_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(w.d), 64'(e.d));
          chk("out_keep", 64'(w.k), 64'(e.k));
        end
      end
      prev_hold  = bus.out_valid && !bus.out_ready;
      prev_valid = bus.out_valid;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
      prev_fd    = flush_done;
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
    if (acc_pending) bus.fifo_data = src_q.pop_front();
    bus.fifo_empty = force_ne ? 1'b0 :
                     ((src_q.size() == 0) || ($urandom_range(99) < empty_rate));
    bus.out_ready  = ($urandom_range(99) < ready_rate);
    flush     = flush_req;
    flush_req = 1'b0;
  endtask

  task automatic assert_rst(input int n);
    @(posedge rclk);
    #1;
    rst            = 1'b0;
    force_ne       = 1'b1;
    bus.fifo_empty = 1'b0;
    repeat (n) step();
  endtask

  task automatic release_rst();
    @(posedge rclk);
    #1;
    rst            = 1'b1;
    force_ne       = 1'b0;
    flush          = 1'b0;
    bus.fifo_empty = (src_q.size() == 0);
    @(negedge rclk);
    #1;
    chk("valid_after_release", 64'(bus.out_valid), 64'(0));
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    step();
    step();
    for (int i = 0; i < 200 && flush_out != 0; i++) step();
    chk("flush_completes", 64'(flush_out), 64'(0));
  endtask

  task automatic wait_seen(input int n, input int budget);
    for (int i = 0; i < budget && seen_q.size() < n; i++) step();
    chk("words_arrived", 64'(seen_q.size() >= n), 64'(1));
  endtask

  initial begin
    int fd0;
    rst            = 1'b0;
    flush          = 1'b0;
    bus.out_ready  = 1'b0;
    bus.fifo_data  = 8'h00;
    force_ne       = 1'b1;
    bus.fifo_empty = 1'b0;
    repeat (3) step();
    release_rst();

    // One full word, with first-output latency.
    ready_rate = 100;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wait_seen(1, 30);
    chk("t1_data", 64'(seen_q[0].d), 64'(32'h44332211));
    chk("t1_keep", 64'(seen_q[0].k), 64'(4'hF));
    chk("t1_latency", 64'(valid_rise_cyc - last_full_cyc), 64'(2));
    chk("t1_word_cnt", 64'(word_cnt), 64'(16'd1));

    // Backpressure: first word held, reads stall once the accumulator is full.
    seen_q.delete();
    ready_rate = 0;
    for (int b = 1; b <= 9; b++) src_q.push_back(8'(b));
    repeat (20) step();
    chk("t2_held_valid", 64'(bus.out_valid),  64'(1));
    chk("t2_held_data",  64'(bus.out_data),   64'(32'h04030201));
    chk("t2_stalled",    64'(src_q.size()),   64'(1));
    chk("t2_rd_en_low",  64'(bus.fifo_rd_en), 64'(0));
    ready_rate = 100;
    wait_seen(2, 20);
    chk("t2_word0", 64'(seen_q[0].d), 64'(32'h04030201));
    chk("t2_word1", 64'(seen_q[1].d), 64'(32'h08070605));
    do_flush();
    wait_seen(3, 20);
    chk("t2_tail_data", 64'(seen_q[2].d), 64'(32'h00000009));
    chk("t2_tail_keep", 64'(seen_q[2].k), 64'(4'b0001));

    // Partial word on flush.
    seen_q.delete();
    src_q = '{8'hA1, 8'hB2, 8'hC3};
    repeat (8) step();
    fd0 = fd_pulses;
    do_flush();
    wait_seen(1, 20);
    chk("t3_data", 64'(seen_q[0].d), 64'(32'h00C3B2A1));
    chk("t3_keep", 64'(seen_q[0].k), 64'(4'b0111));
    chk("t3_fd_once", 64'(fd_pulses - fd0), 64'(1));

    // Flush with nothing accumulated.
    seen_q.delete();
    repeat (3) step();
    fd0 = fd_pulses;
    do_flush();
    repeat (4) step();
    chk("t4_fd_once",  64'(fd_pulses - fd0), 64'(1));
    chk("t4_no_word",  64'(seen_q.size()),   64'(0));
    chk("t4_word_cnt", 64'(word_cnt),        64'(16'd5));
    chk("t4_no_valid", 64'(bus.out_valid),   64'(0));

    // Reset mid-word discards the partial accumulation.
    seen_q.delete();
    src_q = '{8'h5A, 8'h6B};
    repeat (5) step();
    assert_rst(3);
    release_rst();
    src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    wait_seen(1, 30);
    chk("t5_data", 64'(seen_q[0].d), 64'(32'hC4C3C2C1));
    repeat (2) step();
    chk("t5_word_cnt", 64'(word_cnt), 64'(16'd1));

    // Randomised stream with empty toggling, random ready and sporadic flush.
    bytes_acc  = 0;
    ready_rate = 50;
    empty_rate = 40;
    for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom));
    for (int i = 0; i < 40000 && src_q.size() != 0; i++) begin
      if (!flush && flush_out == 0 && $urandom_range(63) == 0) flush_req = 1'b1;
      step();
    end
    chk("rand_src_drained", 64'(src_q.size()), 64'(0));
    step();
    step();
    for (int i = 0; i < 200 && flush_out != 0; i++) step();
    ready_rate = 100;
    do_flush();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    chk("rand_all_words_out", 64'(exp_q.size()), 64'(0));
    chk("rand_bytes_read",    64'(bytes_acc),    64'(1000));
    chk("flush_owed_end",     64'(flush_out),    64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
